// File: rtl/fact_pkg.sv
// Shared types and helpers for the factorial engine.
// The sequencer state encoding and the counter width rule live here.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } fact_state_t;

    // One extra bit so cnt can reach n_q+1 without wrapping at the top operand.
    function automatic int cnt_w(input int n_w);
        return n_w + 1;
    endfunction

endpackage

// File: rtl/factorial_unit_dp.sv
// Factorial datapath: operand capture, step counter, comparator, multiplier, accumulator.
// With FACT_OVF_EN defined, a sticky flag records any truncated product bits.
module factorial_unit_dp
    import fact_pkg::*;
#(
    parameter int N_W   = 3,
    parameter int RES_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_n_i,
    input  logic [N_W-1:0]   n_i,
    input  logic             init_i,
    input  logic             step_i,
    output logic             cnt_le_o,
    output logic [RES_W-1:0] acc_o,
    output logic             ovf_o
);

    localparam int CNT_W = cnt_w(N_W);

    logic [N_W-1:0]   n_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] prod_lo;

    assign cnt_le_o = (cnt_q <= CNT_W'(n_q));
    assign acc_o    = acc_q;

`ifdef FACT_OVF_EN
    localparam int PROD_W = RES_W + CNT_W;

    logic [PROD_W-1:0] prod_full;
    logic              prod_hi_nz;
    logic              ovf_q;

    assign prod_full  = PROD_W'(acc_q) * PROD_W'(cnt_q);
    assign prod_lo    = prod_full[RES_W-1:0];
    assign prod_hi_nz = |prod_full[PROD_W-1:RES_W];
    assign ovf_o      = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (init_i) begin
            ovf_q <= 1'b0;
        end else if (step_i) begin
            ovf_q <= ovf_q | prod_hi_nz;
        end
    end
`else
    // Only the low RES_W bits are ever kept, so the narrow product is enough.
    assign prod_lo = acc_q * RES_W'(cnt_q);
    assign ovf_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q <= '0;
        end else if (load_n_i) begin
            n_q <= n_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (init_i) begin
            cnt_q <= CNT_W'(1);
            acc_q <= RES_W'(1);
        end else if (step_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= prod_lo;
        end
    end

endmodule

// File: rtl/factorial_unit.sv
// Self-sequenced n! engine with start/done handshake; FSM plus result registers.
// Optional overflow reporting is enabled by defining FACT_OVF_EN.
module factorial_unit
    import fact_pkg::*;
#(
    parameter int N_W   = 3,
    parameter int RES_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [N_W-1:0]   n_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [RES_W-1:0] result_o,
    output logic             overflow_o
);

    fact_state_t      state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             load_n, init, step;
    logic             cnt_le;
    logic [RES_W-1:0] acc;
    logic             dp_ovf;

    factorial_unit_dp #(
        .N_W   (N_W),
        .RES_W (RES_W)
    ) u_dp (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_n_i (load_n),
        .n_i      (n_i),
        .init_i   (init),
        .step_i   (step),
        .cnt_le_o (cnt_le),
        .acc_o    (acc),
        .ovf_o    (dp_ovf)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load_n   = 1'b0;
        init     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_n  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                init    = 1'b1;
                state_d = MULT;
            end
            MULT: begin
                if (cnt_le) begin
                    step = 1'b1;
                end else begin
                    result_d = acc;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

`ifdef FACT_OVF_EN
    logic overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (state_q == MULT && !cnt_le) begin
            overflow_q <= dp_ovf;
        end
    end

    assign overflow_o = overflow_q;
`else
    // Datapath drives a constant 0 in this build.
    assign overflow_o = dp_ovf;
`endif

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q == INIT) || (state_q == MULT);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule
